param_report_tx: RTL and testbench

Response-packet encoder for the UART command path. It runs in the opposite direction to the command parser: on a report request it snapshots the live acquisition parameters and serialises a framed packet (header, type, length, payload) onto the byte stream toward the UART transmitter. It honours transmitter backpressure.

---
 rtl/param_pkg.sv | 92 +++++++++
 rtl/param_payload_mux.sv | 45 ++++
 rtl/param_report_tx.sv | 168 ++++++++++++++++
 tb/tb_param_report_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_pkg.sv
// param_pkg: shared report/command codes for the UART command path.
// Holds request type codes, payload lengths, the packet header byte,
// the parameter snapshot layout and the byte order of the full dump.
// Both the command parser and the report encoder import this package so
// the codes on either side of the link cannot drift apart.
package param_pkg;

    localparam logic [7:0] HEADER           = 8'h55;

    localparam logic [7:0] TYPE_CHANNEL     = 8'd1;
    localparam logic [7:0] TYPE_SPEED       = 8'd2;
    localparam logic [7:0] TYPE_ADC_START   = 8'd3;
    localparam logic [7:0] TYPE_ADC_TRIG    = 8'd4;
    localparam logic [7:0] TYPE_FLASH_START = 8'd6;
    localparam logic [7:0] TYPE_FLASH_NUM   = 8'd7;
    localparam logic [7:0] TYPE_DUMP        = 8'd10;
    localparam logic [7:0] TYPE_ERR         = 8'hEE;

    localparam logic [7:0] LEN_CHANNEL      = 8'd1;
    localparam logic [7:0] LEN_SPEED        = 8'd3;
    localparam logic [7:0] LEN_ADC_START    = 8'd1;
    localparam logic [7:0] LEN_ADC_TRIG     = 8'd1;
    localparam logic [7:0] LEN_FLASH_START  = 8'd1;
    localparam logic [7:0] LEN_FLASH_NUM    = 8'd2;
    localparam logic [7:0] LEN_DUMP         = 8'd9;
    localparam logic [7:0] LEN_ERR          = 8'd1;

    // Header, type and length bytes precede every payload.
    localparam logic [7:0] FRAME_OVERHEAD   = 8'd3;

    typedef struct packed {
        logic [7:0]  channel;
        logic [23:0] speed;
        logic        adc_start;
        logic        adc_trig;
        logic        flash_start;
        logic [15:0] flash_num;
    } param_snap_t;

    typedef enum logic [3:0] {
        F_CHANNEL,
        F_SPEED_LO,
        F_SPEED_MID,
        F_SPEED_HI,
        F_ADC_START,
        F_ADC_TRIG,
        F_FLASH_START,
        F_FLASH_NUM_LO,
        F_FLASH_NUM_HI,
        F_REQ_TYPE,
        F_NONE
    } field_e;

    // Payload byte order of the full dump, indexed by payload byte number.
    localparam field_e DUMP_ORDER [0:8] = '{
        F_CHANNEL, F_SPEED_LO, F_SPEED_MID, F_SPEED_HI,
        F_ADC_START, F_ADC_TRIG, F_FLASH_START,
        F_FLASH_NUM_LO, F_FLASH_NUM_HI
    };

    // Payload length of the single-parameter types; 0 means "not a
    // single-parameter type". The dump type is left out on purpose so the
    // dump code stays overridable at the encoder.
    function automatic logic [7:0] payload_len(input logic [7:0] t);
        case (t)
            TYPE_CHANNEL:     return LEN_CHANNEL;
            TYPE_SPEED:       return LEN_SPEED;
            TYPE_ADC_START:   return LEN_ADC_START;
            TYPE_ADC_TRIG:    return LEN_ADC_TRIG;
            TYPE_FLASH_START: return LEN_FLASH_START;
            TYPE_FLASH_NUM:   return LEN_FLASH_NUM;
            default:          return 8'd0;
        endcase
    endfunction

    // 1-bit parameters are zero-extended to a full byte.
    function automatic logic [7:0] field_byte(input param_snap_t s, input field_e f);
        case (f)
            F_CHANNEL:      return s.channel;
            F_SPEED_LO:     return s.speed[7:0];
            F_SPEED_MID:    return s.speed[15:8];
            F_SPEED_HI:     return s.speed[23:16];
            F_ADC_START:    return {7'd0, s.adc_start};
            F_ADC_TRIG:     return {7'd0, s.adc_trig};
            F_FLASH_START:  return {7'd0, s.flash_start};
            F_FLASH_NUM_LO: return s.flash_num[7:0];
            F_FLASH_NUM_HI: return s.flash_num[15:8];
            default:        return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/param_payload_mux.sv
// param_payload_mux: combinational payload byte selector.
// Ports:
//   i_snap     - registered parameter snapshot
//   i_req_type - registered requested type
//   i_idx      - payload byte index (0 = first payload byte)
//   o_data     - payload byte for that index
// Unsupported types return the requested type itself as their only byte.
module param_payload_mux
    import param_pkg::*;
#(
    parameter logic [7:0] P_DUMP_TYPE = TYPE_DUMP
) (
    input  param_snap_t i_snap,
    input  logic [7:0]  i_req_type,
    input  logic [7:0]  i_idx,
    output logic [7:0]  o_data
);

    field_e fld;

    always_comb begin
        fld = F_NONE;
        if (i_req_type == P_DUMP_TYPE) begin
            if (i_idx < LEN_DUMP) begin
                fld = DUMP_ORDER[i_idx[3:0]];
            end
        end else begin
            case (i_req_type)
                TYPE_CHANNEL:     fld = F_CHANNEL;
                TYPE_SPEED:       fld = (i_idx == 8'd0) ? F_SPEED_LO :
                                        (i_idx == 8'd1) ? F_SPEED_MID : F_SPEED_HI;
                TYPE_ADC_START:   fld = F_ADC_START;
                TYPE_ADC_TRIG:    fld = F_ADC_TRIG;
                TYPE_FLASH_START: fld = F_FLASH_START;
                TYPE_FLASH_NUM:   fld = (i_idx == 8'd0) ? F_FLASH_NUM_LO : F_FLASH_NUM_HI;
                default:          fld = F_REQ_TYPE;
            endcase
        end
    end

    always_comb begin
        o_data = (fld == F_REQ_TYPE) ? i_req_type : field_byte(i_snap, fld);
    end

endmodule

// File: rtl/param_report_tx.sv
// param_report_tx: response-packet encoder for the UART command path.
// On an accepted report request, snapshots the live acquisition parameters
// and emits header, type, length and payload bytes toward the UART
// transmitter, honouring its ready/valid backpressure.
// Ports:
//   i_clk, i_rst                - clock, asynchronous active-high reset
//   i_req_type/valid, o_req_ready - report request handshake
//   i_adc_*, i_flash_*          - live parameters, sampled on acceptance
//   o_cmd_len                   - total packet length (payload + 3)
//   o_cmd_data/last/valid, i_cmd_ready - outgoing byte stream
module param_report_tx
    import param_pkg::*;
#(
    parameter logic [7:0] P_HEADER    = HEADER,
    parameter logic [7:0] P_DUMP_TYPE = TYPE_DUMP,
    parameter logic [7:0] P_ERR_TYPE  = TYPE_ERR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_req_type,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [7:0]  i_adc_channel,
    input  logic [23:0] i_adc_speed,
    input  logic        i_adc_start,
    input  logic        i_adc_trig,
    input  logic        i_flash_start,
    input  logic [15:0] i_flash_num,
    output logic [7:0]  o_cmd_len,
    output logic [7:0]  o_cmd_data,
    output logic        o_cmd_last,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_TYPE,
        S_LEN,
        S_DATA
    } state_e;

    state_e      state, state_nxt;
    param_snap_t snap;
    logic [7:0]  snap_req_type, snap_reply_type, snap_plen;
    logic [7:0]  byte_cnt;
    logic [7:0]  dec_plen, dec_reply, known_len;
    logic [7:0]  payload_byte;
    logic        accept, xfer, last_byte;

    assign accept    = i_req_valid && (state == S_IDLE);
    assign xfer      = o_cmd_valid && i_cmd_ready;
    assign last_byte = (state == S_DATA) && (byte_cnt == snap_plen - 8'd1);

    // Request decode: dump, single parameter, or error reply.
    always_comb begin
        known_len = payload_len(i_req_type);
        if (i_req_type == P_DUMP_TYPE) begin
            dec_plen  = LEN_DUMP;
            dec_reply = i_req_type;
        end else if (known_len != 8'd0) begin
            dec_plen  = known_len;
            dec_reply = i_req_type;
        end else begin
            dec_plen  = LEN_ERR;
            dec_reply = P_ERR_TYPE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap            <= '0;
            snap_req_type   <= '0;
            snap_reply_type <= '0;
            snap_plen       <= '0;
        end else if (accept) begin
            snap.channel     <= i_adc_channel;
            snap.speed       <= i_adc_speed;
            snap.adc_start   <= i_adc_start;
            snap.adc_trig    <= i_adc_trig;
            snap.flash_start <= i_flash_start;
            snap.flash_num   <= i_flash_num;
            snap_req_type    <= i_req_type;
            snap_reply_type  <= dec_reply;
            snap_plen        <= dec_plen;
        end
    end

    // Payload byte counter: cleared when the length byte leaves, stops at
    // payload length - 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byte_cnt <= '0;
        end else if (state == S_LEN && xfer) begin
            byte_cnt <= '0;
        end else if (state == S_DATA && xfer && !last_byte) begin
            byte_cnt <= byte_cnt + 8'd1;
        end
    end

    param_payload_mux #(
        .P_DUMP_TYPE (P_DUMP_TYPE)
    ) u_payload_mux (
        .i_snap     (snap),
        .i_req_type (snap_req_type),
        .i_idx      (byte_cnt),
        .o_data     (payload_byte)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_req_valid) state_nxt = S_HEAD;
            S_HEAD:  if (i_cmd_ready) state_nxt = S_TYPE;
            S_TYPE:  if (i_cmd_ready) state_nxt = S_LEN;
            S_LEN:   if (i_cmd_ready) state_nxt = S_DATA;
            S_DATA:  if (i_cmd_ready && last_byte) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_cmd_valid = 1'b0;
        o_cmd_data  = '0;
        o_cmd_last  = 1'b0;
        o_cmd_len   = '0;
        case (state)
            S_IDLE: begin
                o_req_ready = 1'b1;
            end
            S_HEAD: begin
                o_cmd_valid = 1'b1;
                o_cmd_data  = P_HEADER;
                o_cmd_len   = snap_plen + FRAME_OVERHEAD;
            end
            S_TYPE: begin
                o_cmd_valid = 1'b1;
                o_cmd_data  = snap_reply_type;
                o_cmd_len   = snap_plen + FRAME_OVERHEAD;
            end
            S_LEN: begin
                o_cmd_valid = 1'b1;
                o_cmd_data  = snap_plen;
                o_cmd_len   = snap_plen + FRAME_OVERHEAD;
            end
            S_DATA: begin
                o_cmd_valid = 1'b1;
                o_cmd_data  = payload_byte;
                o_cmd_last  = last_byte;
                o_cmd_len   = snap_plen + FRAME_OVERHEAD;
            end
            default: begin
                o_req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_param_report_tx.sv
// tb_param_report_tx: self-checking bench for param_report_tx.
// Expected packets come from a queue-based reference model built from the
// packet format (header, reply type, payload length, payload bytes).
module tb_param_report_tx;

    typedef logic [7:0] bq_t[$];

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_req_type;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_adc_channel;
    logic [23:0] i_adc_speed;
    logic        i_adc_start;
    logic        i_adc_trig;
    logic        i_flash_start;
    logic [15:0] i_flash_num;
    logic [7:0]  o_cmd_len;
    logic [7:0]  o_cmd_data;
    logic        o_cmd_last;
    logic        o_cmd_valid;
    logic        i_cmd_ready;

    int n_checks = 0;
    int n_errors = 0;

    bq_t exp_q;
    bq_t next_q;

    param_report_tx #(
        .P_HEADER    (8'h55),
        .P_DUMP_TYPE (8'd10),
        .P_ERR_TYPE  (8'hEE)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_type    (i_req_type),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_adc_channel (i_adc_channel),
        .i_adc_speed   (i_adc_speed),
        .i_adc_start   (i_adc_start),
        .i_adc_trig    (i_adc_trig),
        .i_flash_start (i_flash_start),
        .i_flash_num   (i_flash_num),
        .o_cmd_len     (o_cmd_len),
        .o_cmd_data    (o_cmd_data),
        .o_cmd_last    (o_cmd_last),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference packet for a request, from the current parameter inputs.
    function automatic bq_t model_packet(input logic [7:0] t);
        bq_t pl;
        bq_t pkt;
        logic [7:0] rtype;
        rtype = t;
        case (t)
            8'd1: pl.push_back(i_adc_channel);
            8'd2: begin
                pl.push_back(i_adc_speed[7:0]);
                pl.push_back(i_adc_speed[15:8]);
                pl.push_back(i_adc_speed[23:16]);
            end
            8'd3: pl.push_back({7'd0, i_adc_start});
            8'd4: pl.push_back({7'd0, i_adc_trig});
            8'd6: pl.push_back({7'd0, i_flash_start});
            8'd7: begin
                pl.push_back(i_flash_num[7:0]);
                pl.push_back(i_flash_num[15:8]);
            end
            8'd10: begin
                pl.push_back(i_adc_channel);
                pl.push_back(i_adc_speed[7:0]);
                pl.push_back(i_adc_speed[15:8]);
                pl.push_back(i_adc_speed[23:16]);
                pl.push_back({7'd0, i_adc_start});
                pl.push_back({7'd0, i_adc_trig});
                pl.push_back({7'd0, i_flash_start});
                pl.push_back(i_flash_num[7:0]);
                pl.push_back(i_flash_num[15:8]);
            end
            default: begin
                rtype = 8'hEE;
                pl.push_back(t);
            end
        endcase
        pkt.push_back(8'h55);
        pkt.push_back(rtype);
        pkt.push_back(8'(pl.size()));
        foreach (pl[k]) pkt.push_back(pl[k]);
        return pkt;
    endfunction

    task automatic scramble();
        i_adc_channel = 8'($urandom);
        i_adc_speed   = 24'($urandom);
        i_adc_start   = 1'($urandom);
        i_adc_trig    = 1'($urandom);
        i_flash_start = 1'($urandom);
        i_flash_num   = 16'($urandom);
    endtask

    task automatic arm_request(input logic [7:0] t, output bq_t q);
        i_req_type  = t;
        i_req_valid = 1'b1;
        q = model_packet(t);
    endtask

    // Entered at a negedge with a request asserted and exp_q loaded.
    // mode: 0 ready always high, 1 ready toggles 1,0,1,0..., 2 random ready.
    // chain: arm a second request (chain_type) while this packet is in flight.
    task automatic run_packet(input int mode, input bit chain, input logic [7:0] chain_type);
        int budget;
        int i;
        int cyc;
        int n;
        logic r;
        budget = 0;
        while (!o_req_ready) begin
            if (budget > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                return;
            end
            budget++;
            @(negedge i_clk);
        end
        @(negedge i_clk);
        i_req_valid = 1'b0;
        // Inputs move after acceptance; the packet must not follow them.
        scramble();
        if (chain) arm_request(chain_type, next_q);
        n = exp_q.size();
        i = 0;
        cyc = 0;
        while (i < n) begin
            if (cyc > 200) begin
                check("packet_timeout", 32'd0, 32'd1);
                return;
            end
            check("valid", {31'd0, o_cmd_valid}, 32'd1);
            check("data", {24'd0, o_cmd_data}, {24'd0, exp_q[i]});
            check("last", {31'd0, o_cmd_last}, (i == n - 1) ? 32'd1 : 32'd0);
            check("len", {24'd0, o_cmd_len}, 32'(n));
            check("req_ready_busy", {31'd0, o_req_ready}, 32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_cmd_ready = r;
            if (r) i++;
            cyc++;
            @(negedge i_clk);
        end
        check("gap_valid", {31'd0, o_cmd_valid}, 32'd0);
        check("req_ready_after", {31'd0, o_req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        logic [7:0] codes [7];
        codes = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd10};

        i_rst = 1'b1;
        i_req_type = '0;
        i_req_valid = 1'b0;
        i_cmd_ready = 1'b0;
        i_adc_channel = '0;
        i_adc_speed = '0;
        i_adc_start = 1'b0;
        i_adc_trig = 1'b0;
        i_flash_start = 1'b0;
        i_flash_num = '0;
        #1;
        check("rst_valid", {31'd0, o_cmd_valid}, 32'd0);
        check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        check("rst_data", {24'd0, o_cmd_data}, 32'd0);
        check("rst_last", {31'd0, o_cmd_last}, 32'd0);
        check("rst_len", {24'd0, o_cmd_len}, 32'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Speed report, ready held high.
        scramble();
        i_adc_speed = 24'h0186A0;
        arm_request(8'd2, exp_q);
        run_packet(0, 1'b0, 8'd0);

        // Full dump with fixed parameter values.
        @(negedge i_clk);
        i_adc_channel = 8'd3;
        i_adc_speed = 24'h123456;
        i_adc_start = 1'b1;
        i_adc_trig = 1'b0;
        i_flash_start = 1'b1;
        i_flash_num = 16'hBEEF;
        arm_request(8'd10, exp_q);
        run_packet(0, 1'b0, 8'd0);

        // Unsupported type -> error reply.
        @(negedge i_clk);
        scramble();
        arm_request(8'd5, exp_q);
        run_packet(0, 1'b0, 8'd0);

        // Flash count with ready toggling; inputs change mid-packet.
        @(negedge i_clk);
        scramble();
        i_flash_num = 16'h0102;
        arm_request(8'd7, exp_q);
        run_packet(1, 1'b0, 8'd0);

        // Second request held during a packet, accepted right after it.
        @(negedge i_clk);
        scramble();
        arm_request(8'd1, exp_q);
        run_packet(2, 1'b1, 8'd10);
        exp_q = next_q;
        run_packet(0, 1'b0, 8'd0);

        // Reset pulsed while the type byte is on the bus.
        @(negedge i_clk);
        scramble();
        arm_request(8'd2, exp_q);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_cmd_ready = 1'b1;
        check("rst_test_head", {24'd0, o_cmd_data}, 32'h55);
        @(negedge i_clk);
        check("rst_test_type", {24'd0, o_cmd_data}, {24'd0, exp_q[1]});
        #2 i_rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, o_cmd_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, o_req_ready}, 32'd1);
        check("midrst_len", {24'd0, o_cmd_len}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("postrst_valid", {31'd0, o_cmd_valid}, 32'd0);
        check("postrst_req_ready", {31'd0, o_req_ready}, 32'd1);
        scramble();
        arm_request(8'd6, exp_q);
        run_packet(0, 1'b0, 8'd0);

        // Randomized requests and backpressure.
        for (int k = 0; k < 25; k++) begin
            @(negedge i_clk);
            scramble();
            if ($urandom_range(0, 3) == 0) t = 8'($urandom);
            else t = codes[$urandom_range(0, 6)];
            arm_request(t, exp_q);
            run_packet(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), codes[$urandom_range(0, 6)]);
            if (i_req_valid) begin
                exp_q = next_q;
                run_packet(0, 1'b0, 8'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
